freq_err_avg: RTL and testbench
===============================

FREQ_ERR_AVG -- requirements
Module: freq_err_avg

Interface
REQ-001 Parameter TARGET, default 32'd10000, expected gate-window count of the measured clock.
REQ-002 Parameter AVG_SHIFT, default 3, log2 of samples averaged (N = 2^AVG_SHIFT = 8).
REQ-003 Parameter ERR_LIMIT, default 32'd1000, max accepted |error| per sample.
REQ-004 Parameter UNLOCK_RUN, default 4, consecutive rejects that raise unlock.
REQ-005 clk  input  1  block clock; all inputs synchronous to it.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  averaging enable; low flushes partial accumulation.
REQ-008 valid_freq_in  input  1  count-valid level from the frequency counter, held high ~17 clk per window.
REQ-009 freq_in  input  32  unsigned count of the measured clock per gate window.
REQ-010 clear  input  1  one-cycle pulse clearing unlock, overrun and reject_cnt.
REQ-011 avg_valid  output  1  one-cycle pulse, avg_err updated.
REQ-012 avg_err  output  32  signed two's-complement mean error (freq_in - TARGET).
REQ-013 outlier  output  1  one-cycle pulse on a rejected sample.
REQ-014 reject_cnt  output  16  saturating count of rejected samples.
REQ-015 unlock  output  1  sticky; UNLOCK_RUN consecutive rejects seen.
REQ-016 overrun  output  1  sticky; valid edge arrived while not in IDLE.

Function
REQ-017 valid_d1 SHALL register valid_freq_in; edge = valid_freq_in & ~valid_d1; one sample per rising edge regardless of high duration.
REQ-018 FSM states: IDLE, CALC, CHECK, OUT; reset state IDLE.
REQ-019 IDLE: on edge with en=1, sample_reg <= freq_in, -> CALC; else stay.
REQ-020 CALC: err_reg (33-bit signed) <= {1'b0,sample_reg} - {1'b0,TARGET}, -> CHECK.
REQ-021 CHECK reject (|err_reg| > ERR_LIMIT): outlier=1 for one cycle, reject_cnt +1 saturating at 16'hFFFF, run_cnt +1, accumulator untouched, -> IDLE.
REQ-022 CHECK accept (|err_reg| == ERR_LIMIT accepted): acc += sign-extended err_reg, sample_cnt +1, run_cnt <= 0; -> OUT if sample_cnt was N-1, else IDLE.
REQ-023 acc width = 33 + AVG_SHIFT bits signed; no overflow possible.
REQ-024 OUT: avg_err <= acc >>> AVG_SHIFT (arithmetic, floor), saturated to 32-bit signed range; avg_valid=1 this cycle only; acc, sample_cnt <= 0; -> IDLE.
REQ-025 Latency: avg_valid high exactly 3 clk after the clk edge sampling the Nth accepted valid edge.
REQ-026 avg_err holds its value between updates.
REQ-027 unlock set when run_cnt reaches UNLOCK_RUN; stays set until clear or reset; further rejects keep it set.
REQ-028 Edge while state != IDLE: sample dropped, overrun set sticky.
REQ-029 en=0: acc, sample_cnt, run_cnt <= 0 next cycle, FSM -> IDLE, edges ignored (not overrun); avg_err, stickies, reject_cnt unchanged.
REQ-030 clear coincident with a reject: clear wins for unlock/overrun; reject_cnt <= 1 only if that reject occurs same cycle, else 0.
REQ-031 Rejects do not reset sample_cnt; average covers N accepted samples.

Reset
REQ-032 rst_n low asynchronously: FSM IDLE; valid_d1, sample_reg, err_reg, acc, sample_cnt, run_cnt = 0; avg_valid, outlier, unlock, overrun = 0; avg_err = 0; reject_cnt = 0.
REQ-033 Reset mid-accumulation discards partial sums; first avg_valid after release needs N fresh accepted samples.
REQ-034 valid_freq_in already high at reset release SHALL NOT count as an edge until it falls and rises again (valid_d1 loads on first clk).

Verification
REQ-035 8 windows freq_in=10005, valid high 17 clk each -> one avg_valid pulse, avg_err=5, 3 clk after 8th edge.
REQ-036 7 windows 10000 + 1 window 9999 -> avg_err=-1 (floor); 8 windows 9997 -> avg_err=-3.
REQ-037 freq_in=12000 -> outlier pulse, reject_cnt=1, avg cycle unaffected; 4 consecutive 12000 -> unlock=1; clear -> unlock=0, reject_cnt=0.
REQ-038 freq_in=11000 (|err|=1000) accepted; 11001 rejected.
REQ-039 5 accepted samples then rst_n low mid-cycle -> all outputs 0; next avg_valid only after 8 new samples.
REQ-040 Second valid edge injected 1 clk after first (FSM in CALC) -> overrun=1, sample dropped; en low for 1 clk after 3 samples -> next average needs 8 new samples.

Source files
------------

// File: rtl/freq_err_avg.sv
// Averages (freq_in - TARGET) over 2^AVG_SHIFT accepted gate windows,
// rejecting outliers and flagging loss of lock and overrun.
module freq_err_avg #(
    parameter logic [31:0] TARGET     = 32'd10000,
    parameter int          AVG_SHIFT  = 3,
    parameter logic [31:0] ERR_LIMIT  = 32'd1000,
    parameter int          UNLOCK_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        valid_freq_in,
    input  logic [31:0] freq_in,
    input  logic        clear,
    output logic        avg_valid,
    output logic [31:0] avg_err,
    output logic        outlier,
    output logic [15:0] reject_cnt,
    output logic        unlock,
    output logic        overrun
);

    localparam int AW = 33 + AVG_SHIFT;
    localparam int CW = AVG_SHIFT + 1;
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    localparam logic [CW-1:0] LAST    = CW'((1 << AVG_SHIFT) - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(UNLOCK_RUN);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]           r_state;
    logic                 r_armed;
    logic                 r_valid_d1;
    logic [31:0]          r_sample;
    logic signed [32:0]   r_err;
    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [RW-1:0]        r_run;
    logic                 r_avg_valid;
    logic [31:0]          r_avg_err;
    logic                 r_outlier;
    logic [15:0]          r_rej;
    logic                 r_unlock;
    logic                 r_overrun;

    logic                 w_edge;
    logic signed [32:0]   w_lim;
    logic                 w_reject;
    logic                 w_rej_ev;
    logic signed [AW-1:0] w_err_ext;
    logic signed [AW-1:0] w_shift;
    logic [AW-32:0]       w_hi;
    logic                 w_ovf;
    logic [31:0]          w_avg;
    logic [RW-1:0]        w_run_inc;

    // r_armed masks a level already high when reset releases
    assign w_edge    = valid_freq_in & ~r_valid_d1 & r_armed;
    assign w_lim     = $signed({1'b0, ERR_LIMIT});
    assign w_reject  = (r_err > w_lim) || (r_err < -w_lim);
    assign w_rej_ev  = en && (r_state == CHECK) && w_reject;
    assign w_err_ext = {{AVG_SHIFT{r_err[32]}}, r_err};
    assign w_shift   = r_acc >>> AVG_SHIFT;
    assign w_hi      = w_shift[AW-1:31];
    assign w_ovf     = ~((&w_hi) | ~(|w_hi));
    assign w_avg     = w_ovf ? (w_shift[AW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                             : w_shift[31:0];
    assign w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + RW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_valid_d1  <= 1'b0;
            r_sample    <= '0;
            r_err       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_run       <= '0;
            r_avg_valid <= 1'b0;
            r_avg_err   <= '0;
            r_outlier   <= 1'b0;
        end else begin
            r_armed     <= 1'b1;
            r_valid_d1  <= valid_freq_in;
            r_avg_valid <= 1'b0;
            r_outlier   <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_run   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_edge) begin
                            r_sample <= freq_in;
                            r_state  <= CALC;
                        end
                    end
                    CALC: begin
                        r_err   <= $signed({1'b0, r_sample}) - $signed({1'b0, TARGET});
                        r_state <= CHECK;
                    end
                    CHECK: begin
                        if (w_reject) begin
                            r_outlier <= 1'b1;
                            r_run     <= w_run_inc;
                            r_state   <= IDLE;
                        end else begin
                            r_acc   <= r_acc + w_err_ext;
                            r_cnt   <= r_cnt + CW'(1);
                            r_run   <= '0;
                            r_state <= (r_cnt == LAST) ? OUT : IDLE;
                        end
                    end
                    OUT: begin
                        r_avg_err   <= w_avg;
                        r_avg_valid <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // clear dominates the stickies; a same-cycle reject still counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rej     <= '0;
            r_unlock  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (clear) begin
                r_rej     <= w_rej_ev ? 16'd1 : 16'd0;
                r_unlock  <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                if (w_rej_ev && r_rej != 16'hFFFF)
                    r_rej <= r_rej + 16'd1;
                if (w_rej_ev && w_run_inc == RUN_MAX)
                    r_unlock <= 1'b1;
                if (en && w_edge && r_state != IDLE)
                    r_overrun <= 1'b1;
            end
        end
    end

    assign avg_valid  = r_avg_valid;
    assign avg_err    = r_avg_err;
    assign outlier    = r_outlier;
    assign reject_cnt = r_rej;
    assign unlock     = r_unlock;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_freq_err_avg.sv
// Directed-vector bench for freq_err_avg with hand-computed expectations.
module tb_freq_err_avg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        valid_freq_in;
    logic [31:0] freq_in;
    logic        clear;
    logic        avg_valid;
    logic [31:0] avg_err;
    logic        outlier;
    logic [15:0] reject_cnt;
    logic        unlock;
    logic        overrun;

    int n_vec;
    int n_err;
    int cyc;
    int e_cyc;
    int av_cyc;
    int av_cnt;
    int ol_cnt;

    freq_err_avg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .valid_freq_in(valid_freq_in),
        .freq_in      (freq_in),
        .clear        (clear),
        .avg_valid    (avg_valid),
        .avg_err      (avg_err),
        .outlier      (outlier),
        .reject_cnt   (reject_cnt),
        .unlock       (unlock),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avg_valid) begin
            av_cnt <= av_cnt + 1;
            av_cyc <= cyc;
        end
        if (outlier)
            ol_cnt <= ol_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic win(input logic [31:0] f);
        @(negedge clk);
        freq_in       = f;
        valid_freq_in = 1'b1;
        e_cyc         = cyc + 1;
        repeat (17) @(negedge clk);
        valid_freq_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wins(input int n, input logic [31:0] f);
        for (int i = 0; i < n; i++) win(f);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        av_cnt = 0; ol_cnt = 0; av_cyc = 0; e_cyc = 0;
        rst_n = 1'b0; en = 1'b1; valid_freq_in = 1'b0;
        freq_in = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_avg_valid", 32'(avg_valid), 32'd0);
        check("rst_avg_err", avg_err, 32'd0);
        check("rst_outlier", 32'(outlier), 32'd0);
        check("rst_reject_cnt", 32'(reject_cnt), 32'd0);
        check("rst_unlock", 32'(unlock), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        wins(8, 32'd10005);
        check("avg5_count", 32'(av_cnt), 32'd1);
        check("avg5_value", avg_err, 32'd5);
        check("avg5_latency", 32'(av_cyc - e_cyc), 32'd3);
        repeat (10) @(negedge clk);
        check("avg5_hold", avg_err, 32'd5);
        check("avg5_pulse_low", 32'(avg_valid), 32'd0);

        wins(7, 32'd10000);
        win(32'd9999);
        check("floor_m1_count", 32'(av_cnt), 32'd2);
        check("floor_m1_value", avg_err, 32'hFFFF_FFFF);
        wins(8, 32'd9997);
        check("m3_count", 32'(av_cnt), 32'd3);
        check("m3_value", avg_err, 32'hFFFF_FFFD);

        wins(4, 32'd10000);
        win(32'd12000);
        wins(4, 32'd10000);
        check("rej_outlier_cnt", 32'(ol_cnt), 32'd1);
        check("rej_reject_cnt", 32'(reject_cnt), 32'd1);
        check("rej_avg_count", 32'(av_cnt), 32'd4);
        check("rej_avg_value", avg_err, 32'd0);
        check("rej_no_unlock", 32'(unlock), 32'd0);
        wins(3, 32'd12000);
        check("run3_no_unlock", 32'(unlock), 32'd0);
        win(32'd12000);
        check("run4_unlock", 32'(unlock), 32'd1);
        check("run4_reject_cnt", 32'(reject_cnt), 32'd5);
        check("run4_outliers", 32'(ol_cnt), 32'd5);
        pulse_clear();
        check("clr_unlock", 32'(unlock), 32'd0);
        check("clr_reject_cnt", 32'(reject_cnt), 32'd0);

        win(32'd11000);
        win(32'd11001);
        wins(7, 32'd10000);
        check("lim_reject_cnt", 32'(reject_cnt), 32'd1);
        check("lim_avg_count", 32'(av_cnt), 32'd5);
        check("lim_avg_value", avg_err, 32'd125);

        wins(5, 32'd10001);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_avg_err", avg_err, 32'd0);
        check("mrst_reject_cnt", 32'(reject_cnt), 32'd0);
        check("mrst_avg_valid", 32'(avg_valid), 32'd0);
        check("mrst_outlier", 32'(outlier), 32'd0);
        check("mrst_unlock", 32'(unlock), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        freq_in = 32'd10008;
        valid_freq_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        valid_freq_in = 1'b0;
        repeat (3) @(negedge clk);
        wins(7, 32'd10008);
        check("mrst_no_early_avg", 32'(av_cnt), 32'd5);
        win(32'd10008);
        check("mrst_avg_count", 32'(av_cnt), 32'd6);
        check("mrst_avg_value", avg_err, 32'd8);

        @(negedge clk);
        freq_in = 32'd10016;
        valid_freq_in = 1'b1;
        @(negedge clk);
        valid_freq_in = 1'b0;
        freq_in = 32'd10000;
        @(negedge clk);
        valid_freq_in = 1'b1;
        @(negedge clk);
        valid_freq_in = 1'b0;
        repeat (5) @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        pulse_clear();
        check("ovr_clear", 32'(overrun), 32'd0);
        wins(7, 32'd10000);
        check("ovr_avg_count", 32'(av_cnt), 32'd7);
        check("ovr_avg_value", avg_err, 32'd2);

        wins(3, 32'd10040);
        @(negedge clk);
        en = 1'b0;
        win(32'd10040);
        en = 1'b1;
        check("en_no_overrun", 32'(overrun), 32'd0);
        wins(7, 32'd10000);
        check("en_no_early_avg", 32'(av_cnt), 32'd7);
        win(32'd10000);
        check("en_avg_count", 32'(av_cnt), 32'd8);
        check("en_avg_value", avg_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
